// File: rtl/untether.sv
// untether: RMII Ethernet frame receiver with destination filtering, header/FCS stripping and CRC-32 verdict
//   clk    : 50 MHz RMII reference clock, rising edge
//   rst    : asynchronous active-high reset
//   crsdv  : RMII carrier-sense/data-valid
//   rxd    : RMII receive dibit, rxd[0] earlier on the wire
//   axiov  : payload dibit valid (registered)
//   axiod  : payload dibit (registered)
//   done   : one-cycle pulse at end of every frame that reached DATA
//   fcs_ok : CRC/length/destination verdict, only high together with done
module untether #(
  parameter logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91,
  parameter bit ACCEPT_BC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       fcs_ok
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [12:0] CNT_MAX = 13'd6000;
  // MAC with byte order reversed so dibit n of the wire sits at bits [2n+1:2n]
  localparam logic [63:0] MAC_LE = {16'h0, MY_MAC[7:0], MY_MAC[15:8], MY_MAC[23:16],
                                    MY_MAC[31:24], MY_MAC[39:32], MY_MAC[47:40]};
  state_t state;
  logic crsdv_q;
  logic [12:0] count;
  logic [31:0] crc;
  logic [31:0] crc_next;
  // 16-dibit delay line, newest in [1:0], oldest in [31:30]; holds back the FCS
  logic [31:0] line;
  logic uc_ok;
  logic bc_ok;
  logic [1:0] mac_dibit;
  logic dest_match;
  logic good;
  always_comb begin
    crc_next = crc;
    for (int k = 0; k < 2; k++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ rxd[k]) ? POLY : 32'h0);
    mac_dibit = MAC_LE[{count[4:0], 1'b0} +: 2];
    dest_match = uc_ok | (ACCEPT_BC & bc_ok);
    good = (crc == RESIDUE) && (count >= 13'd72) && (count[1:0] == 2'b00) && dest_match;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      crsdv_q <= 1'b1;
      count <= '0;
      crc <= '1;
      line <= '0;
      uc_ok <= 1'b0;
      bc_ok <= 1'b0;
      axiov <= 1'b0;
      axiod <= 2'b00;
      done <= 1'b0;
      fcs_ok <= 1'b0;
    end else begin
      crsdv_q <= crsdv;
      axiov <= 1'b0;
      axiod <= 2'b00;
      done <= 1'b0;
      fcs_ok <= 1'b0;
      case (state)
        IDLE: if (crsdv && !crsdv_q && rxd == 2'b01) state <= PRE;
        PRE: begin
          if (!crsdv) state <= IDLE;
          else if (rxd == 2'b11) begin
            state <= DATA;
            count <= '0;
            crc <= '1;
            line <= '0;
            uc_ok <= 1'b1;
            bc_ok <= 1'b1;
          end else if (rxd != 2'b01) state <= DROP;
        end
        DATA: begin
          if (!crsdv) begin
            state <= IDLE;
            done <= 1'b1;
            fcs_ok <= good;
          end else begin
            count <= (count == CNT_MAX) ? count : count + 13'd1;
            crc <= crc_next;
            line <= {line[29:0], rxd};
            // destination flags freeze once all 24 DA dibits have been seen
            if (count < 13'd24) begin
              uc_ok <= uc_ok & (rxd == mac_dibit);
              bc_ok <= bc_ok & (rxd == 2'b11);
            end
            // the dibit leaving the line is payload only once it is past the 56-dibit header
            axiov <= dest_match && (count >= 13'd72);
            axiod <= (dest_match && (count >= 13'd72)) ? line[31:30] : 2'b00;
          end
        end
        DROP: if (!crsdv) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_untether.sv
// tb_untether: scoreboard bench for the untether RMII receiver
module tb_untether;
  typedef logic [7:0] bq_t[$];
  typedef logic [1:0] dq_t[$];
  localparam logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BC = 48'hFF_FF_FF_FF_FF_FF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic axiov;
  logic [1:0] axiod;
  logic done;
  logic fcs_ok;
  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];
  bit done_q[$];
  untether dut (.clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .axiov(axiov), .axiod(axiod), .done(done), .fcs_ok(fcs_ok));
  always #10 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (axiov) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL axiod unexpected got=%b want=none", axiod);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (axiod !== e) begin
          bad++;
          $display("FAIL axiod got=%b want=%b", axiod, e);
        end
      end
    end
    if (done) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done unexpected got=1 want=0");
      end else begin
        bit e;
        e = done_q.pop_front();
        if (fcs_ok !== e) begin
          bad++;
          $display("FAIL fcs_ok got=%b want=%b", fcs_ok, e);
        end
      end
      total++;
      if (exp_q.size() != 0 || axiov) begin
        bad++;
        $display("FAIL done_order pending=%0d axiov=%b want pending=0 axiov=0", exp_q.size(), axiov);
      end
    end else if (fcs_ok) begin
      total++;
      bad++;
      $display("FAIL fcs_ok_without_done got=1 want=0");
    end
  end
  function automatic bq_t frame(input logic [47:0] da, input bq_t pl);
    bq_t f;
    logic [31:0] c;
    for (int k = 0; k < 6; k++) f.push_back(da[47-8*k -: 8]);
    f = {f, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
    f = {f, pl};
    c = '1;
    foreach (f[n]) for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ f[n][i]) ? 32'hEDB88320 : 32'h0);
    c = ~c;
    f = {f, c[7:0], c[15:8], c[23:16], c[31:24]};
    return f;
  endfunction
  function automatic dq_t dib(input bq_t b);
    dq_t d;
    foreach (b[n]) for (int k = 0; k < 4; k++) d.push_back(b[n][2*k +: 2]);
    return d;
  endfunction
  function automatic bq_t pre();
    bq_t p;
    p = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    return p;
  endfunction
  task automatic push_pl(input bq_t pl, input int n);
    dq_t d;
    d = dib(pl);
    for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
  endtask
  task automatic send(input dq_t d, input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 crsdv = 1'b1;
      rxd = d[i];
    end
    if (drop) begin
      @(posedge clk);
      #1 crsdv = 1'b0;
      rxd = 2'b00;
      repeat (4) @(posedge clk);
    end
  endtask
  initial begin
    bq_t pl;
    bq_t big;
    bq_t f;
    dq_t w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_axiov", {31'h0, axiov}, 32'h0);
    chk("reset_axiod", {30'h0, axiod}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_fcs_ok", {31'h0, fcs_ok}, 32'h0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    // 1: broadcast, two payload bytes
    pl = {8'hA5, 8'h3C};
    exp_q = {exp_q, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};
    done_q.push_back(1'b1);
    w = dib({pre(), frame(BC, pl)});
    send(w, w.size(), 1'b1);
    // 2: same frame, corrupted FCS
    f = frame(BC, pl);
    f[f.size()-1] ^= 8'h10;
    push_pl(pl, 8);
    done_q.push_back(1'b0);
    w = dib({pre(), f});
    send(w, w.size(), 1'b1);
    // 3: foreign unicast destination
    done_q.push_back(1'b0);
    w = dib({pre(), frame(48'h02_00_00_00_00_01, pl)});
    send(w, w.size(), 1'b1);
    // 4a: carrier drops after 40 DATA dibits
    done_q.push_back(1'b0);
    w = dib({pre(), frame(BC, pl)});
    send(w, 32 + 40, 1'b1);
    // 4b: 46-byte payload to own MAC
    big = {};
    for (int i = 0; i < 46; i++) big.push_back(8'(i * 37 + 5));
    push_pl(big, 184);
    done_q.push_back(1'b1);
    w = dib({pre(), frame(MY_MAC, big)});
    send(w, w.size(), 1'b1);
    // 5: bad preamble goes to DROP, next frame is fine
    w = dib({8'h55, 8'h55, 8'h45, frame(BC, pl)});
    send(w, w.size(), 1'b1);
    push_pl(pl, 8);
    done_q.push_back(1'b1);
    w = dib({pre(), frame(BC, pl)});
    send(w, w.size(), 1'b1);
    // 6: reset mid-payload, release while carrier still high
    push_pl(big, 28);
    w = dib({pre(), frame(BC, big)});
    send(w, 32 + 101, 1'b0);
    @(posedge clk);
    #2 chk("pre_rst_axiov", {31'h0, axiov}, 32'h1);
    rst = 1'b1;
    #1 chk("rst_axiov", {31'h0, axiov}, 32'h0);
    chk("rst_axiod", {30'h0, axiod}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_queue", exp_q.size(), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1 rxd = (i % 8 == 7) ? 2'b11 : 2'b01;
    end
    @(posedge clk);
    #1 crsdv = 1'b0;
    rxd = 2'b00;
    repeat (4) @(posedge clk);
    chk("after_rst_silent", done_q.size(), 32'h0);
    push_pl(big, 184);
    done_q.push_back(1'b1);
    w = dib({pre(), frame(BC, big)});
    send(w, w.size(), 1'b1);
    repeat (5) @(posedge clk);
    chk("final_exp_q", exp_q.size(), 32'h0);
    chk("final_done_q", done_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
